regs_exec_ctrl: RTL and testbench

- Multi-cycle execute controller that drives the REGS register file.
- Accepts one ALU instruction per valid/ready handshake and reads both source registers through REGS read ports 0/1.
- Computes the result internally, then writes it back through REGS write port 2.
- Sits between instruction decode and REGS; strictly serialised, one instruction in flight.

---
 rtl/regs_exec_ctrl.sv | 151 +++++++++++++++
 tb/tb_regs_exec_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regs_exec_ctrl.sv
// regs_exec_ctrl: serialised ALU execute controller in front of the REGS register file.
// Each instruction runs through four one-cycle states: IDLE (accept), READ
// (source registers on REGS read ports 0/1), EXEC (ALU and flags) and WB
// (result on REGS write port 2).
// Ports:
//   i_CLK, i_RSTn        clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready     instruction handshake; o_ready is high only in IDLE
//   i_op, i_rd, i_rs1, i_rs2  opcode and register indices
//   o_reg0/o_reg1        REGS read addresses, nonzero only in READ
//   i_data0/i_data1      REGS combinational read data
//   o_reg2/o_data2       REGS write address/data; o_reg2 is nonzero only in WB
//   o_done               one-cycle pulse in WB
//   o_carry, o_zero      flags of the last executed instruction
module regs_exec_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  output logic [ADDR_WIDTH-1:0] o_reg0,
  output logic [ADDR_WIDTH-1:0] o_reg1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic [ADDR_WIDTH-1:0] o_reg2,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic                  o_done,
  output logic                  o_carry,
  output logic                  o_zero
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;

  state_t                  state, state_nxt;
  logic [2:0]              op_q, op_nxt;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_nxt;
  logic [DATA_WIDTH-1:0]   a_q, a_nxt, b_q, b_nxt;
  logic [ADDR_WIDTH-1:0]   reg0_nxt, reg1_nxt, reg2_nxt;
  logic [DATA_WIDTH-1:0]   data2_nxt;
  logic                    done_nxt, carry_nxt, zero_nxt;
  logic [DATA_WIDTH:0]     sum_w, diff_w;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;

  assign o_ready = (state == ST_IDLE);

  // ALU on the latched operands; the extra top bit of sum/diff is carry/borrow
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res   = a_q;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum_w[DATA_WIDTH-1:0];  alu_carry = sum_w[DATA_WIDTH];  end
      OP_SUB: begin alu_res = diff_w[DATA_WIDTH-1:0]; alu_carry = diff_w[DATA_WIDTH]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin alu_res = {a_q[DATA_WIDTH-2:0], 1'b0}; alu_carry = a_q[DATA_WIDTH-1]; end
      OP_SHR: begin alu_res = {1'b0, a_q[DATA_WIDTH-1:1]}; alu_carry = a_q[0]; end
      default: alu_res = a_q;
    endcase
  end

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    rd_nxt    = rd_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    reg0_nxt  = '0;
    reg1_nxt  = '0;
    reg2_nxt  = '0;
    data2_nxt = o_data2;
    done_nxt  = 1'b0;
    carry_nxt = o_carry;
    zero_nxt  = o_zero;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          op_nxt    = i_op;
          rd_nxt    = i_rd;
          reg0_nxt  = i_rs1;
          reg1_nxt  = i_rs2;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        a_nxt     = i_data0;
        b_nxt     = i_data1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        data2_nxt = alu_res;
        carry_nxt = alu_carry;
        zero_nxt  = (alu_res == '0);
        reg2_nxt  = rd_q;
        done_nxt  = 1'b1;
        state_nxt = ST_WB;
      end
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      o_reg0  <= '0;
      o_reg1  <= '0;
      o_reg2  <= '0;
      o_data2 <= '0;
      o_done  <= 1'b0;
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      rd_q    <= rd_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      o_reg0  <= reg0_nxt;
      o_reg1  <= reg1_nxt;
      o_reg2  <= reg2_nxt;
      o_data2 <= data2_nxt;
      o_done  <= done_nxt;
      o_carry <= carry_nxt;
      o_zero  <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_regs_exec_ctrl.sv
// Bench for regs_exec_ctrl paired with a small REGS model (16 registers,
// r1=10, r2=5 after load). Vectors carry hand-computed results; expected
// writebacks are queued at accept and compared when the DUT reaches WB.
module tb_regs_exec_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned REG_COUNT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [2:0]    op = '0;
  logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [AW-1:0] reg0, reg1, reg2;
  logic [DW-1:0] data0, data1, data2;
  logic          done, carry, zero;

  regs_exec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .o_reg0(reg0), .o_reg1(reg1), .i_data0(data0), .i_data1(data1),
    .o_reg2(reg2), .o_data2(data2), .o_done(done), .o_carry(carry), .o_zero(zero)
  );

  always #5 clk = ~clk;

  // REGS model: combinational reads, write at the clock edge, r0 never written
  logic [DW-1:0] rf [REG_COUNT];
  logic          rf_load = 1'b1;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < int'(REG_COUNT); i++)
        rf[i] <= (i == 1) ? 8'd10 : (i == 2) ? 8'd5 : 8'd0;
    end else if (reg2 != '0 && reg2 < AW'(REG_COUNT)) begin
      rf[reg2[3:0]] <= data2;
    end
  end
  assign data0 = (reg0 < AW'(REG_COUNT)) ? rf[reg0[3:0]] : '0;
  assign data1 = (reg1 < AW'(REG_COUNT)) ? rf[reg1[3:0]] : '0;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] data;
    logic          carry, zero, b2b;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  vec_t sb [$];
  vec_t cur;

  int pass_cnt = 0, total_cnt = 0;
  int phase = 0, cyc = 0, acc_cyc = 0, prev_acc_cyc = 0;
  logic [AW-1:0] exp_rs1, exp_rs2;
  logic [DW-1:0] last_data = '0;
  logic last_carry = 1'b0, last_zero = 1'b0;
  logic accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: note accept before the edge, advance the phase model, then check at negedge
  task automatic tick();
    logic acc;
    vec_t e;
    acc = valid && ready;
    if (acc) begin
      sb.push_back(cur);
      exp_rs1 = cur.rs1;
      exp_rs2 = cur.rs2;
    end
    @(posedge clk);
    cyc++;
    if (acc) begin
      phase = 1; accepted = 1'b1; prev_acc_cyc = acc_cyc; acc_cyc = cyc;
    end else if (phase == 3) phase = 0;
    else if (phase != 0) phase++;
    @(negedge clk);
    case (phase)
      1: begin
        chk("read_ready", 32'(ready), 0);
        chk("read_reg0", 32'(reg0), 32'(exp_rs1));
        chk("read_reg1", 32'(reg1), 32'(exp_rs2));
        chk("read_done", 32'(done), 0);
      end
      2: begin
        chk("exec_ready", 32'(ready), 0);
        chk("exec_reg0", 32'(reg0), 0);
        chk("exec_reg2", 32'(reg2), 0);
        chk("exec_done", 32'(done), 0);
      end
      3: begin
        chk("wb_done", 32'(done), 1);
        chk("wb_ready", 32'(ready), 0);
        if (sb.size() == 0) chk("wb_sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wb_reg2", 32'(reg2), 32'(e.rd));
          chk("wb_data2", 32'(data2), 32'(e.data));
          chk("wb_carry", 32'(carry), 32'(e.carry));
          chk("wb_zero", 32'(zero), 32'(e.zero));
          last_data = e.data; last_carry = e.carry; last_zero = e.zero;
        end
      end
      default: begin
        chk("idle_ready", 32'(ready), 1);
        chk("idle_done", 32'(done), 0);
        chk("idle_reg2", 32'(reg2), 0);
        chk("idle_reg0", 32'(reg0), 0);
      end
    endcase
    if (phase != 3) begin
      chk("hold_carry", 32'(carry), 32'(last_carry));
      chk("hold_zero", 32'(zero), 32'(last_zero));
      chk("hold_data2", 32'(data2), 32'(last_data));
    end
  endtask

  task automatic issue(input vec_t v, input logic prev_b2b);
    int n;
    cur = v; op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 10) begin tick(); n++; end
    if (!accepted) chk("accept_timeout", 0, 1);
    if (prev_b2b) chk("b2b_spacing", 32'(acc_cyc - prev_acc_cyc), 4);
    if (!v.b2b) begin
      valid = 1'b0;
      n = 0;
      while ((phase != 0 || sb.size() != 0) && n < 10) begin tick(); n++; end
      if (phase != 0 || sb.size() != 0) chk("drain_timeout", 0, 1);
    end
  endtask

  // Start an instruction, stop it with reset once the phase model reaches target
  task automatic reset_during(input vec_t v, input int target);
    int n;
    cur = v; op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (phase != target && n < 12) begin
      tick(); n++;
      if (accepted) valid = 1'b0;
    end
    if (phase != target) chk("reset_reach_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_reg2", 32'(reg2), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_data2", 32'(data2), 0);
    sb.delete();
    phase = 0; last_data = '0; last_carry = 1'b0; last_zero = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 1);
    chk("post_rst_r3", 32'(rf[3]), 32'h0F);
    tick();
  endtask

  logic [DW-1:0] exp_rf [REG_COUNT];
  vec_t rv;

  initial begin
    //              op    rd     rs1    rs2    data    c     z     b2b
    vecs[0]  = '{3'd0, 5'd3,  5'd1, 5'd2, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 5'd4,  5'd2, 5'd1, 8'hFB, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd0, 5'd0,  5'd1, 5'd2, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd0, 5'd3,  5'd1, 5'd2, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'd7, 5'd5,  5'd3, 5'd0, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 5'd6,  5'd1, 5'd1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 5'd7,  5'd1, 5'd0, 8'h14, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd0, 5'd8,  5'd4, 5'd4, 8'hF6, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd2, 5'd9,  5'd1, 5'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd3, 5'd10, 5'd1, 5'd2, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd6, 5'd11, 5'd4, 5'd0, 8'h7D, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd5, 5'd12, 5'd4, 5'd0, 8'hF6, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'd1, 5'd13, 5'd1, 5'd2, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd1, 5'd14, 5'd2, 5'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{3'd7, 5'd20, 5'd4, 5'd1, 8'hFB, 1'b0, 1'b0, 1'b0};
    rv       = '{3'd0, 5'd3,  5'd4, 5'd1, 8'h05, 1'b1, 1'b0, 1'b0};
    exp_rf = '{8'h00, 8'h0A, 8'h05, 8'h0F, 8'hFB, 8'h0F, 8'h00, 8'h14,
               8'hF6, 8'h00, 8'h0F, 8'h7D, 8'hF6, 8'h05, 8'h00, 8'h00};

    @(negedge clk);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_reg012", 32'({reg0, reg1, reg2}), 0);
    chk("reset_data2", 32'(data2), 0);
    chk("reset_flags", 32'({done, carry, zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rf_load = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      issue(vecs[i], (i > 0) ? vecs[i-1].b2b : 1'b0);

    for (int i = 0; i < int'(REG_COUNT); i++)
      chk("final_rf", 32'(rf[i]), 32'(exp_rf[i]));

    reset_during(rv, 2);
    reset_during(rv, 3);
    chk("end_r3", 32'(rf[3]), 32'h0F);

    issue(vecs[12], 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
